// File: rtl/fetch_bram_sched.sv
// rtl/fetch_bram_sched.sv - round-robin scheduler sharing one fetch_bram among N_REQ requesters
module fetch_bram_sched #(
  parameter int N_REQ          = 4,
  parameter int ID_W           = 2,
  parameter int RST_PTR_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_W           = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] cfg_buf_sel,
  input  logic [N_REQ-1:0]   cfg_tiles,
  input  logic [N_REQ-1:0]   cfg_dbuf,
  input  logic [N_REQ-1:0]   cfg_rst_ptr,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               err_timeout,
  output logic [ID_W-1:0]    err_id,
  input  logic               err_clr,
  output logic               start_fetch,
  output logic               reset_addr_counter,
  output logic [3:0]         Buffer_Select,
  output logic               Tiles_Control,
  output logic               Double_buffering,
  input  logic               fetch_done,
  input  logic               fetch_busy
);

  typedef enum logic [2:0] {S_IDLE, S_RSTP, S_START, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   idx_q, idx_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              start_q, start_d;
  logic              rap_q, rap_d;
  logic [3:0]        bsel_q, bsel_d;
  logic              tiles_q, tiles_d;
  logic              dbuf_q, dbuf_d;
  logic              err_q, err_d;
  logic [ID_W-1:0]   err_id_q, err_id_d;
  logic              err_set;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   scan_idx;
  int                scan_pos;

  // Round-robin pick: first requesting index at or after rr_q, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_pos = (int'(rr_q) + i) % N_REQ;
      scan_idx = ID_W'(scan_pos);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state and registered-output computation for the grant sequence
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    start_d  = 1'b0;
    rap_d    = 1'b0;
    bsel_d   = bsel_q;
    tiles_d  = tiles_q;
    dbuf_d   = dbuf_q;
    err_id_d = err_id_q;
    err_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found && !fetch_busy) begin
          idx_d   = win_idx;
          gnt_d   = N_REQ'(1) << win_idx;
          bsel_d  = cfg_buf_sel[{win_idx, 2'b00} +: 4];
          tiles_d = cfg_tiles[win_idx];
          dbuf_d  = cfg_dbuf[win_idx];
          cnt_d   = '0;
          state_d = cfg_rst_ptr[win_idx] ? S_RSTP : S_START;
        end
      end
      S_RSTP: begin
        rap_d = 1'b1;
        if (cnt_q == TO_W'(RST_PTR_CYCLES - 1)) begin
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fetch_done) begin
          done_d[idx_q] = 1'b1;
          state_d       = S_DONE;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          done_d[idx_q] = 1'b1;
          err_set       = 1'b1;
          err_id_d      = idx_q;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        rr_d    = (idx_q == ID_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A watchdog set in the same cycle as a clear must win
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // State and output registers; async reset abandons any transaction silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      rap_q    <= 1'b0;
      bsel_q   <= '0;
      tiles_q  <= 1'b0;
      dbuf_q   <= 1'b0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      start_q  <= start_d;
      rap_q    <= rap_d;
      bsel_q   <= bsel_d;
      tiles_q  <= tiles_d;
      dbuf_q   <= dbuf_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign gnt                = gnt_q;
  assign done               = done_q;
  assign start_fetch        = start_q;
  assign reset_addr_counter = rap_q;
  assign Buffer_Select      = bsel_q;
  assign Tiles_Control      = tiles_q;
  assign Double_buffering   = dbuf_q;
  assign err_timeout        = err_q;
  assign err_id             = err_id_q;

endmodule

// File: tb/tb_fetch_bram_sched.sv
// tb/tb_fetch_bram_sched.sv - self-checking bench for fetch_bram_sched
module tb_fetch_bram_sched;

  localparam int TMO = 16;
  localparam int RSTC = 2;

  logic        clk, rst_n;
  logic [3:0]  req;
  logic [15:0] cfg_buf_sel;
  logic [3:0]  cfg_tiles, cfg_dbuf, cfg_rst_ptr;
  logic [3:0]  gnt, done;
  logic        err_timeout, err_clr;
  logic [1:0]  err_id;
  logic        start_fetch, reset_addr_counter;
  logic [3:0]  Buffer_Select;
  logic        Tiles_Control, Double_buffering;
  logic        fetch_done, fetch_busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int model_ptr = 0;

  fetch_bram_sched #(
    .N_REQ(4), .ID_W(2), .RST_PTR_CYCLES(RSTC), .TIMEOUT_CYCLES(TMO), .TO_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cfg_buf_sel(cfg_buf_sel),
    .cfg_tiles(cfg_tiles), .cfg_dbuf(cfg_dbuf), .cfg_rst_ptr(cfg_rst_ptr),
    .gnt(gnt), .done(done), .err_timeout(err_timeout), .err_id(err_id),
    .err_clr(err_clr), .start_fetch(start_fetch),
    .reset_addr_counter(reset_addr_counter), .Buffer_Select(Buffer_Select),
    .Tiles_Control(Tiles_Control), .Double_buffering(Double_buffering),
    .fetch_done(fetch_done), .fetch_busy(fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbitration rule: first pending requester at or after ptr, modulo 4
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  // One full transaction observed from the requester side, checked against the model
  task automatic serve(input string nm, input int exp_lat, input int delay,
                       input bit to, input bit stray, output int w);
    int k, rc, n;
    logic [3:0] eb, oh;
    logic et, ed, erp;
    bit got;
    w   = pick(req, model_ptr);
    eb  = cfg_buf_sel[4*w +: 4];
    et  = cfg_tiles[w];
    ed  = cfg_dbuf[w];
    erp = cfg_rst_ptr[w];
    oh  = 4'(1) << w;
    got = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (gnt !== 4'b0) begin got = 1; break; end
    end
    total_cnt++;
    if (!got) begin
      $display("FAIL %s grant_wait gnt=%b expected=%b", nm, gnt, oh);
      return;
    end
    pass_cnt++;
    if (exp_lat > 0) begin
      total_cnt++;
      if (k !== exp_lat) $display("FAIL %s grant_latency got=%0d expected=%0d", nm, k, exp_lat);
      else pass_cnt++;
    end
    total_cnt++;
    if (gnt !== oh) $display("FAIL %s gnt got=%b expected=%b", nm, gnt, oh);
    else pass_cnt++;
    total_cnt++;
    if ({Buffer_Select, Tiles_Control, Double_buffering} !== {eb, et, ed})
      $display("FAIL %s cfg_at_grant got=%h/%b/%b expected=%h/%b/%b", nm,
               Buffer_Select, Tiles_Control, Double_buffering, eb, et, ed);
    else pass_cnt++;
    if (stray) fetch_done = 1'b1;
    cfg_buf_sel = 16'($urandom);
    cfg_tiles   = 4'($urandom);
    cfg_dbuf    = 4'($urandom);
    cfg_rst_ptr = 4'($urandom);
    rc = 0;
    got = 0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      fetch_done = 1'b0;
      if (reset_addr_counter) rc++;
      if (start_fetch) begin got = 1; break; end
    end
    total_cnt++;
    if (!got || rc !== (erp ? RSTC : 0) || k !== rc)
      $display("FAIL %s rstp_start got_start=%0d rst_cycles=%0d start_after=%0d expected=%0d", nm, got, rc, k, erp ? RSTC : 0);
    else pass_cnt++;
    total_cnt++;
    if ({Buffer_Select, Tiles_Control, Double_buffering} !== {eb, et, ed})
      $display("FAIL %s cfg_at_start got=%h/%b/%b expected=%h/%b/%b", nm,
               Buffer_Select, Tiles_Control, Double_buffering, eb, et, ed);
    else pass_cnt++;
    if (to) begin
      got = 0;
      for (n = 1; n <= TMO + 10; n++) begin
        @(negedge clk);
        if (n == 1) begin
          total_cnt++;
          if (start_fetch !== 1'b0) $display("FAIL %s start_width got=%b expected=0", nm, start_fetch);
          else pass_cnt++;
        end
        if (done !== 4'b0) begin got = 1; break; end
      end
      total_cnt++;
      if (!got || n !== TMO) $display("FAIL %s timeout_cycles got=%0d expected=%0d", nm, n, TMO);
      else pass_cnt++;
    end else begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        if (i == 0) begin
          total_cnt++;
          if (start_fetch !== 1'b0) $display("FAIL %s start_width got=%b expected=0", nm, start_fetch);
          else pass_cnt++;
        end
        total_cnt++;
        if (done !== 4'b0) $display("FAIL %s early_done got=%b expected=0000", nm, done);
        else pass_cnt++;
      end
      fetch_done = 1'b1;
      @(negedge clk);
      fetch_done = 1'b0;
    end
    total_cnt++;
    if (done !== oh || gnt !== oh)
      $display("FAIL %s done_cycle done=%b gnt=%b expected=%b", nm, done, gnt, oh);
    else pass_cnt++;
    total_cnt++;
    if ({Buffer_Select, Tiles_Control, Double_buffering} !== {eb, et, ed})
      $display("FAIL %s cfg_at_done got=%h/%b/%b expected=%h/%b/%b", nm,
               Buffer_Select, Tiles_Control, Double_buffering, eb, et, ed);
    else pass_cnt++;
    req[w] = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (done !== 4'b0 || gnt !== 4'b0 || Buffer_Select !== eb)
      $display("FAIL %s after_done done=%b gnt=%b bsel=%h expected=0000/0000/%h", nm, done, gnt, Buffer_Select, eb);
    else pass_cnt++;
    model_ptr = (w + 1) % 4;
  endtask

  task automatic check_all_zero(input string nm);
    total_cnt++;
    if ({gnt, done, start_fetch, reset_addr_counter, Buffer_Select, Tiles_Control,
         Double_buffering, err_timeout, err_id} !== 20'b0)
      $display("FAIL %s outputs got gnt=%b done=%b st=%b rap=%b bs=%h t=%b d=%b err=%b id=%0d expected all 0",
               nm, gnt, done, start_fetch, reset_addr_counter, Buffer_Select,
               Tiles_Control, Double_buffering, err_timeout, err_id);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_single();
    int w;
    cfg_buf_sel[3:0] = 4'h0;
    cfg_tiles[0]     = 1'b1;
    cfg_dbuf[0]      = 1'b1;
    cfg_rst_ptr[0]   = 1'b0;
    req = 4'b0001;
    serve("single", 1, 5, 0, 0, w);
  endtask

  task automatic test_rstp();
    int w;
    cfg_rst_ptr = 4'b0100;
    cfg_buf_sel[11:8] = 4'hA;
    req = 4'b0100;
    serve("rstp", 1, 3, 0, 0, w);
  endtask

  task automatic test_timeout();
    int w;
    cfg_rst_ptr = 4'b0000;
    req = 4'b1000;
    total_cnt++;
    if (err_timeout !== 1'b0) $display("FAIL timeout_pre err=%b expected=0", err_timeout);
    else pass_cnt++;
    serve("timeout", -1, 0, 1, 0, w);
    total_cnt++;
    if (err_timeout !== 1'b1 || err_id !== 2'd3)
      $display("FAIL timeout_flag err=%b id=%0d expected=1/3", err_timeout, err_id);
    else pass_cnt++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total_cnt++;
    if (err_timeout !== 1'b0) $display("FAIL err_clr err=%b expected=0", err_timeout);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int order[6];
    int exp_order[6] = '{0, 1, 2, 3, 0, 3};
    cfg_rst_ptr = 4'b0000;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cfg_rst_ptr = 4'b0000;
      serve("rr", -1, 1 + i, 0, 0, order[i]);
    end
    req = 4'b1001;
    for (int i = 4; i < 6; i++) begin
      cfg_rst_ptr = 4'b0000;
      serve("rr_reissue", -1, 2, 0, 0, order[i]);
    end
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (order[i] !== exp_order[i]) $display("FAIL rr_order[%0d] got=%0d expected=%0d", i, order[i], exp_order[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back_busy();
    int w;
    cfg_rst_ptr = 4'b0000;
    fetch_busy = 1'b1;
    req = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total_cnt++;
      if (gnt !== 4'b0) $display("FAIL busy_gate cycle %0d gnt=%b expected=0000", i, gnt);
      else pass_cnt++;
    end
    fetch_busy = 1'b0;
    serve("busy_stray", -1, 3, 0, 1, w);
  endtask

  task automatic test_mid_reset();
    int w;
    bit got;
    cfg_rst_ptr = 4'b0000;
    req = 4'b0100;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0) begin got = 1; break; end
    end
    total_cnt++;
    if (!got || gnt !== 4'b0100) $display("FAIL mrst_grant gnt=%b expected=0100", gnt);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0101;
    #1;
    check_all_zero("mrst_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (done !== 4'b0) $display("FAIL mrst_no_done done=%b expected=0000", done);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    model_ptr = 0;
    serve("mrst_first", 1, 2, 0, 0, w);
    total_cnt++;
    if (w !== 0) $display("FAIL mrst_winner got=%0d expected=0", w);
    else pass_cnt++;
    serve("mrst_second", -1, 2, 0, 0, w);
  endtask

  task automatic test_random();
    int w;
    for (int it = 0; it < 10; it++) begin
      if (req == 4'b0) req = 4'($urandom_range(1, 15));
      cfg_buf_sel = 16'($urandom);
      cfg_tiles   = 4'($urandom);
      cfg_dbuf    = 4'($urandom);
      cfg_rst_ptr = 4'($urandom);
      serve("random", -1, $urandom_range(1, 6), 0, 0, w);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b0;
    cfg_buf_sel = 16'h0;
    cfg_tiles = 4'b0;
    cfg_dbuf = 4'b0;
    cfg_rst_ptr = 4'b0;
    err_clr = 1'b0;
    fetch_done = 1'b0;
    fetch_busy = 1'b0;
    test_reset();
    test_single();
    test_rstp();
    test_timeout();
    test_round_robin();
    test_back_to_back_busy();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
